rom_sequencer: RTL and testbench
================================

ROM_SEQUENCER -- requirements
Module: rom_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, ROM address width (4..16).
REQ-002 Parameter DATA_W, default 8, ROM data width (1..32).
REQ-003 Parameter LATENCY, default 1, ROM read latency in clocks from address to q (1..4).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
REQ-007 stop  in  1  request to end a RUN early; sampled only in RUN.
REQ-008 mode  in  2  0 single-shot, 1 loop, 2 ping-pong, 3 treated as single-shot.
REQ-009 start_addr  in  ADDR_W  first address of scan window.
REQ-010 end_addr  in  ADDR_W  last address of scan window (inclusive).
REQ-011 step  in  ADDR_W  address increment; 0 treated as 1.
REQ-012 rom_addr  out  ADDR_W  registered address to ROM address port.
REQ-013 rom_q  in  DATA_W  ROM read data.
REQ-014 data  out  DATA_W  registered sample.
REQ-015 data_addr  out  ADDR_W  address that produced data.
REQ-016 data_valid  out  1  data/data_addr valid this cycle.
REQ-017 busy  out  1  high in RUN and DRAIN.
REQ-018 done  out  1  one-cycle pulse at scan end.

Function
REQ-019 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN on stop or single-shot end; DRAIN->IDLE when no read in flight, with done pulse in the cycle after DRAIN exits.
REQ-020 On start, mode/start_addr/end_addr/step latched; later input changes ignored until next IDLE.
REQ-021 First RUN cycle drives rom_addr=start_addr; one new address issued every RUN cycle.
REQ-022 Address issued in cycle n yields data_valid=1, data=rom_q, data_addr=that address in cycle n+LATENCY+1.
REQ-023 Next-address arithmetic in ADDR_W+1 bits; up-candidate = addr+step, exceeds window if >end_addr or overflows ADDR_W.
REQ-024 Single-shot: up-candidate out of window -> current address is last issued; go DRAIN.
REQ-025 Loop: up-candidate out of window -> next address start_addr; runs until stop.
REQ-026 Ping-pong: direction up at start; up-candidate out of window -> flip down, next = addr-step, clamped to start_addr; down-candidate <start_addr (signed) -> flip up, next = addr+step, clamped to end_addr; endpoints not repeated when window spans >1 address; single-address window repeats that address.
REQ-027 stop in RUN: no address issued that cycle; in-flight reads still delivered; enter DRAIN.
REQ-028 start while busy ignored; stop in IDLE/DRAIN ignored; start and stop together in IDLE: start wins.
REQ-029 start with start_addr>end_addr: no reads, no data_valid, done pulse two cycles after start, busy high one cycle.
REQ-030 rom_addr holds last issued value in IDLE and DRAIN.

Reset
REQ-031 rst: state IDLE, rom_addr=0, data=0, data_addr=0, data_valid=0, busy=0, done=0, direction up, latched config 0.
REQ-032 rst mid-RUN/DRAIN: in-flight reads discarded, no data_valid and no done afterwards.

Verification (LATENCY=1, ADDR_W=8, ROM content q=~addr)
REQ-033 mode0, 0x10..0x13, step1 -> rom_addr 10,11,12,13 consecutive; data_valid 4 cycles from 2 cycles after first address, data=EF,EE,ED,EC; done once after last valid.
REQ-034 mode1, 0x00..0x05, step2, stop after 5 issues -> addresses 0,2,4,0,2; exactly 5 valids; done.
REQ-035 mode2, 0x02..0x04, step1 -> 2,3,4,3,2,3,4 ...; stop -> pending valids delivered, done.
REQ-036 mode0, 0xF0..0xFF, step 0x20 -> single read at F0 (overflow); mode1 same -> F0 repeated; step=0 behaves as step1.
REQ-037 start_addr=0x08, end_addr=0x04 -> no data_valid, done pulse 2 cycles after start.
REQ-038 rst asserted mid-RUN of REQ-034 -> next cycle busy=0, data_valid=0, rom_addr=0, no done; fresh start works normally.

Source files
------------

// File: rtl/rom_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : rom_sequencer_if
//  Brief    : Control, ROM-port and sample-stream signals of rom_sequencer.
//  Revision : 1.0
// ============================================================================
interface rom_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              start;
    logic              stop;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_q;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] data_addr;
    logic              data_valid;
    logic              busy;
    logic              done;

    modport slave (
        input  start, stop, mode, start_addr, end_addr, step, rom_q,
        output rom_addr, data, data_addr, data_valid, busy, done
    );

    modport master (
        output start, stop, mode, start_addr, end_addr, step, rom_q,
        input  rom_addr, data, data_addr, data_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/rom_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rom_sequencer
//  Brief    : Scans a ROM address window (single-shot, loop, ping-pong) and
//             streams each sample with the address that produced it.
//  Revision : 1.0
// ============================================================================
module rom_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    rom_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic                issue_q, issue_d;
    logic                dir_up_q, dir_up_d;
    logic [1:0]          mode_q, mode_d;
    logic [ADDR_W-1:0]   win_start_q, win_start_d;
    logic [ADDR_W-1:0]   win_end_q, win_end_d;
    logic [ADDR_W-1:0]   step_q, step_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   data_addr_q, data_addr_d;
    logic                data_valid_q, data_valid_d;
    logic [LATENCY-1:0]  vld_pipe_q, vld_pipe_d;
    logic [ADDR_W-1:0]   addr_pipe_q [LATENCY];
    logic [ADDR_W-1:0]   addr_pipe_d [LATENCY];

    logic [ADDR_W:0]     step_eff;
    logic [ADDR_W:0]     up_cand;
    logic                up_out;
    logic                dn_out;
    logic [ADDR_W-1:0]   dn_cand;
    logic [ADDR_W-1:0]   up_clamped;
    logic [ADDR_W-1:0]   dn_clamped;
    logic                in_flight;

    // One extra bit so an increment past the top of the address space is seen
    // as leaving the window instead of wrapping back into it.
    always_comb begin
        step_eff   = (step_q == '0) ? (ADDR_W+1)'(1) : {1'b0, step_q};
        up_cand    = {1'b0, rom_addr_q} + step_eff;
        up_out     = up_cand > {1'b0, win_end_q};
        dn_out     = {1'b0, rom_addr_q} < ({1'b0, win_start_q} + step_eff);
        dn_cand    = rom_addr_q - step_eff[ADDR_W-1:0];
        up_clamped = up_out ? win_end_q : up_cand[ADDR_W-1:0];
        dn_clamped = dn_out ? win_start_q : dn_cand;
        in_flight  = issue_q | (|vld_pipe_q);
    end

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        issue_d     = 1'b0;
        dir_up_d    = dir_up_q;
        mode_d      = mode_q;
        win_start_d = win_start_q;
        win_end_d   = win_end_q;
        step_d      = step_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d      = bus.mode;
                    win_start_d = bus.start_addr;
                    win_end_d   = bus.end_addr;
                    step_d      = bus.step;
                    dir_up_d    = 1'b1;
                    if (bus.start_addr > bus.end_addr) begin
                        state_d = S_DRAIN;
                    end else begin
                        rom_addr_d = bus.start_addr;
                        issue_d    = 1'b1;
                        state_d    = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (bus.stop) begin
                    state_d = S_DRAIN;
                end else begin
                    case (mode_q)
                        2'd1: begin
                            issue_d    = 1'b1;
                            rom_addr_d = up_out ? win_start_q : up_cand[ADDR_W-1:0];
                        end
                        2'd2: begin
                            issue_d = 1'b1;
                            if (dir_up_q) begin
                                if (up_out) begin
                                    dir_up_d   = 1'b0;
                                    rom_addr_d = dn_clamped;
                                end else begin
                                    rom_addr_d = up_cand[ADDR_W-1:0];
                                end
                            end else begin
                                if (dn_out) begin
                                    dir_up_d   = 1'b1;
                                    rom_addr_d = up_clamped;
                                end else begin
                                    rom_addr_d = dn_cand;
                                end
                            end
                        end
                        default: begin
                            if (up_out) begin
                                state_d = S_DRAIN;
                            end else begin
                                issue_d    = 1'b1;
                                rom_addr_d = up_cand[ADDR_W-1:0];
                            end
                        end
                    endcase
                end
            end

            S_DRAIN: begin
                if (!in_flight) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Read-tracking pipeline: the tail stage lines up with rom_q for its address.
    always_comb begin
        vld_pipe_d     = vld_pipe_q;
        addr_pipe_d    = addr_pipe_q;
        vld_pipe_d[0]  = issue_q;
        addr_pipe_d[0] = rom_addr_q;
        for (int i = 1; i < LATENCY; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            addr_pipe_d[i] = addr_pipe_q[i-1];
        end

        data_d       = data_q;
        data_addr_d  = data_addr_q;
        data_valid_d = vld_pipe_q[LATENCY-1];
        if (vld_pipe_q[LATENCY-1]) begin
            data_d      = bus.rom_q;
            data_addr_d = addr_pipe_q[LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rom_addr_q   <= '0;
            issue_q      <= 1'b0;
            dir_up_q     <= 1'b1;
            mode_q       <= '0;
            win_start_q  <= '0;
            win_end_q    <= '0;
            step_q       <= '0;
            done_q       <= 1'b0;
            data_q       <= '0;
            data_addr_q  <= '0;
            data_valid_q <= 1'b0;
            vld_pipe_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                addr_pipe_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            issue_q      <= issue_d;
            dir_up_q     <= dir_up_d;
            mode_q       <= mode_d;
            win_start_q  <= win_start_d;
            win_end_q    <= win_end_d;
            step_q       <= step_d;
            done_q       <= done_d;
            data_q       <= data_d;
            data_addr_q  <= data_addr_d;
            data_valid_q <= data_valid_d;
            vld_pipe_q   <= vld_pipe_d;
            addr_pipe_q  <= addr_pipe_d;
        end
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.data       = data_q;
    assign bus.data_addr  = data_addr_q;
    assign bus.data_valid = data_valid_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom_sequencer
//  Brief    : Scoreboard bench for rom_sequencer against a ROM holding ~addr.
//  Revision : 1.0
// ============================================================================
module tb_rom_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rom_sequencer_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    rom_sequencer #(.ADDR_W(8), .DATA_W(8), .LATENCY(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] rom_q_r;
    always @(posedge clk) rom_q_r <= ~bus.rom_addr;
    assign bus.rom_q = rom_q_r;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   fv_cyc   = 0;
    bit   fv_armed = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [7:0] a);
        exp_q.push_back({a, ~a});
    endtask

    task automatic go(input logic [1:0] m, input logic [7:0] sa, input logic [7:0] ea,
                      input logic [7:0] st, output int k);
        @(posedge clk);
        #1;
        bus.mode       = m;
        bus.start_addr = sa;
        bus.end_addr   = ea;
        bus.step       = st;
        bus.start      = 1'b1;
        k              = cyc;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Called right after go(): raises stop during cycle k+n.
    task automatic stop_at(input int n);
        repeat (n - 1) @(posedge clk);
        #1;
        bus.stop = 1'b1;
        @(posedge clk);
        #1;
        bus.stop = 1'b0;
    endtask

    task automatic finish_test(input string nm, input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles, required one", nm, n);
        end
        repeat (4) @(negedge clk);
        check({nm, "_done_count"}, done_cnt - d0, 1);
        check({nm, "_queue_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int   k;
        int   d0;
        exp_t e;

        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.mode       = 2'd0;
        bus.start_addr = 8'h00;
        bus.end_addr   = 8'h00;
        bus.step       = 8'h00;

        fork
            forever begin
                @(negedge clk);
                if (bus.data_valid === 1'b1) begin
                    if (fv_armed) begin
                        fv_cyc   = cyc;
                        fv_armed = 1'b0;
                    end
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: got addr=0x%0h data=0x%0h, required no valid",
                                 bus.data_addr, bus.data);
                    end else begin
                        e = exp_q.pop_front();
                        check("data_addr", 32'(bus.data_addr), 32'(e.addr));
                        check("data", 32'(bus.data), 32'(e.data));
                    end
                end
                if (bus.done === 1'b1) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_data_valid", 32'(bus.data_valid), 0);
        check("rst_rom_addr", 32'(bus.rom_addr), 0);
        check("rst_data", 32'(bus.data), 0);
        check("rst_data_addr", 32'(bus.data_addr), 0);
        check("rst_done", 32'(bus.done), 0);

        // Single-shot 10..13; inputs scrambled and start re-pulsed mid-run.
        d0 = done_cnt;
        push(8'h10); push(8'h11); push(8'h12); push(8'h13);
        fv_armed = 1'b1;
        go(2'd0, 8'h10, 8'h13, 8'h01, k);
        bus.start_addr = 8'h80;
        bus.end_addr   = 8'hFF;
        bus.mode       = 2'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        finish_test("single", d0);
        check("single_first_valid_cyc", fv_cyc - k, 3);
        check("single_done_cyc", done_cyc - k, 7);

        // Loop 0..5 step 2, stopped after five issues.
        d0 = done_cnt;
        push(8'h00); push(8'h02); push(8'h04); push(8'h00); push(8'h02);
        go(2'd1, 8'h00, 8'h05, 8'h02, k);
        stop_at(5);
        finish_test("loop", d0);

        // Same loop, reset while reads are in flight.
        d0 = done_cnt;
        push(8'h00);
        go(2'd1, 8'h00, 8'h05, 8'h02, k);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstrun_busy", 32'(bus.busy), 0);
        check("rstrun_data_valid", 32'(bus.data_valid), 0);
        check("rstrun_rom_addr", 32'(bus.rom_addr), 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("rstrun_no_done", done_cnt - d0, 0);
        check("rstrun_queue_left", exp_q.size(), 0);

        // Ping-pong 2..4, stopped on the seventh issue.
        d0 = done_cnt;
        push(8'h02); push(8'h03); push(8'h04); push(8'h03);
        push(8'h02); push(8'h03); push(8'h04);
        go(2'd2, 8'h02, 8'h04, 8'h01, k);
        stop_at(7);
        finish_test("pingpong", d0);

        // Overflowing step: single read in single-shot.
        d0 = done_cnt;
        push(8'hF0);
        go(2'd0, 8'hF0, 8'hFF, 8'h20, k);
        finish_test("ovf_single", d0);

        // Overflowing step in loop: F0 repeats.
        d0 = done_cnt;
        push(8'hF0); push(8'hF0); push(8'hF0);
        go(2'd1, 8'hF0, 8'hFF, 8'h20, k);
        stop_at(3);
        finish_test("ovf_loop", d0);

        // Step 0 behaves as step 1; mode 3 behaves as single-shot.
        d0 = done_cnt;
        push(8'h30); push(8'h31); push(8'h32);
        go(2'd3, 8'h30, 8'h32, 8'h00, k);
        finish_test("step0", d0);

        // Empty window: one busy cycle, done two cycles after start.
        d0 = done_cnt;
        go(2'd0, 8'h08, 8'h04, 8'h01, k);
        @(negedge clk);
        check("empty_busy_k1", 32'(bus.busy), 1);
        @(negedge clk);
        check("empty_busy_k2", 32'(bus.busy), 0);
        finish_test("empty", d0);
        check("empty_done_cyc", done_cyc - k, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
